ram_port_arbiter: RTL



---
 rtl/ram_port_arbiter.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/ram_port_arbiter.sv
// ram_port_arbiter: shares one single-port synchronous data RAM between the
// processor core and an external host port. Round-robin on ties; every core
// load/store takes two cycles (issue, then data/commit) and the core is held
// through its enable while the access is in flight or the host owns the RAM.
//
//   state        | meaning
//   -------------+-----------------------------------------------------------
//   ST_IDLE      | RAM free; arbitrate core vs host and issue the winner
//   ST_PROC_DATA | core access returning; load data passed through, commit
//   ST_HOST_DATA | host read returning; one-cycle response pulse
module ram_port_arbiter #(
   parameter  int NUM_RAM_ADDRESS = 256,
   parameter  int DATA_WIDTH      = 32,
   localparam int AW              = $clog2(NUM_RAM_ADDRESS)
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic                  run,
   input  logic                  proc_ram_enable,
   input  logic                  proc_ram_read_write,
   input  logic [AW-1:0]         proc_ram_address,
   input  logic [DATA_WIDTH-1:0] proc_ram_data_write,
   output logic [DATA_WIDTH-1:0] proc_ram_data_read,
   output logic                  proc_enable,
   input  logic                  host_req_valid,
   output logic                  host_req_ready,
   input  logic                  host_req_write,
   input  logic [AW-1:0]         host_req_address,
   input  logic [DATA_WIDTH-1:0] host_req_data,
   output logic                  host_rsp_valid,
   output logic [DATA_WIDTH-1:0] host_rsp_data,
   output logic                  ram_enable,
   output logic                  ram_read_write,
   output logic [AW-1:0]         ram_address,
   output logic [DATA_WIDTH-1:0] ram_data_write,
   input  logic [DATA_WIDTH-1:0] ram_data_read
);

   typedef enum logic [1:0] {
      ST_IDLE      = 2'd0,
      ST_PROC_DATA = 2'd1,
      ST_HOST_DATA = 2'd2
   } state_t;

   typedef enum logic {
      GNT_PROC = 1'b0,
      GNT_HOST = 1'b1
   } grant_t;

   state_t                state_q, state_d;
   grant_t                last_grant_q, last_grant_d;
   logic [DATA_WIDTH-1:0] rd_hold_q, rd_hold_d;

   logic core_req;
   logic host_req;
   logic core_wins;

   assign core_req  = proc_ram_enable && run;
   assign host_req  = host_req_valid;
   // On a tie the requester that did not win last time goes first.
   assign core_wins = core_req && (!host_req || (last_grant_q == GNT_HOST));

   // Next-state, RAM steering and core/host handshakes.
   always_comb begin
      state_d            = state_q;
      last_grant_d       = last_grant_q;
      rd_hold_d          = rd_hold_q;
      ram_enable         = 1'b0;
      ram_read_write     = 1'b0;
      ram_address        = '0;
      ram_data_write     = '0;
      host_req_ready     = 1'b0;
      host_rsp_valid     = 1'b0;
      host_rsp_data      = '0;
      proc_ram_data_read = rd_hold_q;
      // A core instruction without a memory request never stalls; one with a
      // request is held until its data cycle, stores included.
      proc_enable        = run && !(proc_ram_enable && (state_q != ST_PROC_DATA));

      case (state_q)
         ST_IDLE: begin
            if (core_wins) begin
               ram_enable     = 1'b1;
               ram_read_write = proc_ram_read_write;
               ram_address    = proc_ram_address;
               ram_data_write = proc_ram_data_write;
               last_grant_d   = GNT_PROC;
               state_d        = ST_PROC_DATA;
            end else if (host_req) begin
               ram_enable     = 1'b1;
               ram_read_write = host_req_write;
               ram_address    = host_req_address;
               ram_data_write = host_req_data;
               host_req_ready = 1'b1;
               last_grant_d   = GNT_HOST;
               state_d        = host_req_write ? ST_IDLE : ST_HOST_DATA;
            end
         end
         ST_PROC_DATA: begin
            proc_ram_data_read = ram_data_read;
            rd_hold_d          = ram_data_read;
            proc_enable        = run;
            state_d            = ST_IDLE;
         end
         ST_HOST_DATA: begin
            host_rsp_valid = 1'b1;
            host_rsp_data  = ram_data_read;
            state_d        = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      // Outputs are forced quiet for the whole reset window, not just after
      // the next edge, so an aborted host read never shows its response.
      if (!reset_n) begin
         ram_enable         = 1'b0;
         ram_read_write     = 1'b0;
         ram_address        = '0;
         ram_data_write     = '0;
         host_req_ready     = 1'b0;
         host_rsp_valid     = 1'b0;
         host_rsp_data      = '0;
         proc_ram_data_read = '0;
         proc_enable        = 1'b0;
      end
   end

   // State, fairness pointer and load-data hold register.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q      <= ST_IDLE;
         last_grant_q <= GNT_HOST;
         rd_hold_q    <= '0;
      end else begin
         state_q      <= state_d;
         last_grant_q <= last_grant_d;
         rd_hold_q    <= rd_hold_d;
      end
   end

endmodule
